// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined segment adder: parameter legality checks
// and the slice-width derivation used by every stage.
package adder_pkg;

    function automatic bit stages_ok(input int stages);
        return stages >= 1;
    endfunction

    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    function automatic int seg_of(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : 1;
    endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// Combinational SEG-bit ripple adder built from full_adder cells.
module adder_pipe_slice #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);
    for (genvar i = 0; i < SEG; i++) begin : g_bit
        logic ci;
        logic co;
        // Each bit owns its carry net so the chain is a plain sequence of wires.
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (ci),
            .sum (sum[i]),
            .cout(co)
        );
    end

    assign cout = g_bit[SEG-1].co;
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder; the building block of every ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipelined_segment_adder.sv
// Pipelined add/subtract: one SEG-bit slice resolved per stage, carry registered
// between stages, valid/ready on both ends with full backpressure.
module pipelined_segment_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    // Handshake: a beat moves on any rising edge where valid && ready, never otherwise.
    localparam int SEG  = seg_of(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!stages_ok(STAGES) || !width_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_segment_adder: WIDTH must be a positive multiple of STAGES >= 1");
    end

    logic [STAGES-1:0] vld_vec;
    logic [STAGES-1:0] load;

    // A stage may load unless it and every stage after it are full with the output stalled.
    always_comb begin : advance_chain
        logic tail_full;
        tail_full = 1'b1;
        load      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            tail_full = tail_full & vld_vec[k];
            load[k]   = !tail_full || out_ready;
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int W_SRC = WIDTH - k * SEG;

        logic                 vld;
        logic                 c_r;
        logic [(k+1)*SEG-1:0] s_r;
        logic [(k+1)*SEG-1:0] s_next;
        logic                 v_src;
        logic                 c_src;
        logic [W_SRC-1:0]     a_src;
        logic [W_SRC-1:0]     b_src;
        logic [SEG-1:0]       sum_slice;
        logic                 c_slice;

        if (k == 0) begin : g_head
            // Subtract folds into add: invert B and turn borrow-in into carry-in.
            assign v_src  = in_valid;
            assign a_src  = in_a;
            assign b_src  = in_sub ? ~in_b : in_b;
            assign c_src  = in_sub ? ~in_cin : in_cin;
            assign s_next = sum_slice;
        end else begin : g_link
            assign v_src  = g_stage[k-1].vld;
            assign a_src  = g_stage[k-1].g_skew.a_r;
            assign b_src  = g_stage[k-1].g_skew.b_r;
            assign c_src  = g_stage[k-1].c_r;
            assign s_next = {sum_slice, g_stage[k-1].s_r};
        end

        adder_pipe_slice #(.SEG(SEG)) u_slice (
            .a   (a_src[SEG-1:0]),
            .b   (b_src[SEG-1:0]),
            .cin (c_src),
            .sum (sum_slice),
            .cout(c_slice)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (load[k]) begin
                vld <= v_src;
                if (v_src) begin
                    c_r <= c_slice;
                    s_r <= s_next;
                end
            end
        end

        if (k < LAST) begin : g_skew
            // Unresolved upper operand slices ride along with the transaction.
            logic [W_SRC-SEG-1:0] a_r;
            logic [W_SRC-SEG-1:0] b_r;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (load[k] && v_src) begin
                    a_r <= a_src[W_SRC-1:SEG];
                    b_r <= b_src[W_SRC-1:SEG];
                end
            end
        end else begin : g_tail
            logic ovf_r;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (load[k] && v_src) begin
                    ovf_r <= (a_src[SEG-1] == b_src[SEG-1]) && (sum_slice[SEG-1] != a_src[SEG-1]);
                end
            end
        end

        assign vld_vec[k] = vld;
    end

    assign out_valid = g_stage[LAST].vld;
    assign out_sum   = g_stage[LAST].s_r;
    assign out_cout  = g_stage[LAST].c_r;
    assign out_ovf   = g_stage[LAST].g_tail.ovf_r;

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Self-checking bench: arithmetic reference model with an in-order expected
// queue, handshake/occupancy model, stall-hold and reset checks, directed literals.
module tb_pipelined_segment_adder;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    pipelined_segment_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- bookkeeping ----------------
    int n_vec    = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic [W+1:0] exp_q[$];   // {cout, ovf, sum}
    int           cyc_q[$];
    bit           empty_q[$];

    bit           rst_seen     = 1'b0;
    bit           stalled_prev = 1'b0;
    bit           head_seen    = 1'b0;
    bit           saw_bp       = 1'b0;
    bit           soak_done    = 1'b0;
    logic [W+2:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        int           ua = a;
        int           ub = b;
        int           sa = $signed(a);
        int           sb = $signed(b);
        int           r;
        int           u;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        if (!sub) begin
            u  = ua + ub + int'(cin);
            s  = u[W-1:0];
            co = (u > 65535);
            r  = sa + sb + int'(cin);
        end else begin
            u  = ua - ub - int'(cin);
            s  = u[W-1:0];
            co = (ua >= ub + int'(cin));
            r  = sa - sb - int'(cin);
        end
        ov = (r > 32767) || (r < -32768);
        return {co, ov, s};
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin : compare
        int lat;
        if (rst_seen) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_sum", {16'd0, out_sum}, 32'd0);
            check("rst_out_cout_ovf", {30'd0, out_cout, out_ovf}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        if (rst) begin
            exp_q.delete();
            cyc_q.delete();
            empty_q.delete();
            stalled_prev = 1'b0;
            head_seen    = 1'b0;
        end else begin
            check("in_ready", {31'd0, in_ready},
                  {31'd0, (exp_q.size() < S) || out_ready});
            if (!in_ready) saw_bp = 1'b1;
            if (stalled_prev)
                check("stall_hold", {13'd0, out_valid, out_cout, out_ovf, out_sum}, {13'd0, held});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        lat = cyc - cyc_q[0];
                        if (empty_q[0]) check("latency", lat, S);
                        else            check("latency_min", {31'd0, lat >= S}, 32'd1);
                    end
                    if (out_ready) begin
                        check("result", {14'd0, out_cout, out_ovf, out_sum}, {14'd0, exp_q[0]});
                        void'(exp_q.pop_front());
                        void'(cyc_q.pop_front());
                        void'(empty_q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            stalled_prev = out_valid && !out_ready;
            held         = {out_valid, out_cout, out_ovf, out_sum};
            if (in_valid && in_ready) begin
                empty_q.push_back(exp_q.size() == 0);
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
                cyc_q.push_back(cyc);
            end
        end
        rst_seen = rst;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output int acc);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        acc      = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                n_vec++;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready got 0 for 200 cycles, expected 1");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] edges [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    task automatic send_rand();
        int acc;
        send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W-1:0] e_sum,
                            input logic e_cout, input logic e_ovf);
        int t0;
        bit seen = 1'b0;
        send(a, b, cin, sub, t0);
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check({name, "_sum"}, {16'd0, out_sum}, {16'd0, e_sum});
                check({name, "_cout_ovf"}, {30'd0, out_cout, out_ovf}, {30'd0, e_cout, e_ovf});
                check({name, "_latency"}, cyc - t0, S);
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        directed("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_bin",    16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);

        // Back-to-back burst with the sink stalled for cycles 3..6.
        saw_bp = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("burst_backpressure", {31'd0, saw_bp}, 32'd1);

        // Partially filled pipe discarded by a one-cycle reset.
        for (int i = 0; i < 3; i++) send_rand();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        directed("post_reset", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

        // Random soak with random sink backpressure.
        soak_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_rand();
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                soak_done = 1'b1;
            end
            begin
                while (!soak_done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
